// File: rtl/seg_pkg.sv
// Shared 7-segment encoding for the Basys3 display path.
// Patterns are active-low cathodes in bit6=a .. bit0=g order.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_NONE = 4'hF;

  typedef struct packed {
    logic [3:0] digit;
    logic       is_digit;
    logic       is_blank;
  } seg_decode_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the seg_pkg pattern table: cathode pattern to
// BCD digit plus digit/blank flags.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0]  pattern,
  output seg_decode_t result
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    result.digit    = DIGIT_NONE;
    result.is_digit = 1'b0;
    result.is_blank = 1'b0;
    case (pattern)
      SEG_0:     begin result.digit = 4'd0; result.is_digit = 1'b1; end
      SEG_1:     begin result.digit = 4'd1; result.is_digit = 1'b1; end
      SEG_2:     begin result.digit = 4'd2; result.is_digit = 1'b1; end
      SEG_3:     begin result.digit = 4'd3; result.is_digit = 1'b1; end
      SEG_4:     begin result.digit = 4'd4; result.is_digit = 1'b1; end
      SEG_5:     begin result.digit = 4'd5; result.is_digit = 1'b1; end
      SEG_6:     begin result.digit = 4'd6; result.is_digit = 1'b1; end
      SEG_7:     begin result.digit = 4'd7; result.is_digit = 1'b1; end
      SEG_8:     begin result.digit = 4'd8; result.is_digit = 1'b1; end
      SEG_9:     begin result.digit = 4'd9; result.is_digit = 1'b1; end
      SEG_BLANK: result.is_blank = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors the multiplexed 7-segment drive and rebuilds the per-position
// digit values the player actually sees.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   anode,
  input  logic [6:0]              cathode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    update,
  output logic [IDX_W-1:0]        update_idx,
  output logic                    frame_done,
  output logic                    anode_fault
);

  localparam int CNT_W = 8;

  logic [NUM_DIGITS-1:0] s_anode;
  logic [6:0]            s_cathode;
  logic [CNT_W-1:0]      stable_cnt;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_set;
  logic [IDX_W-1:0]      sample_idx;
  logic                  raw_legal;
  logic                  raw_multi;
  logic                  raw_same;
  logic                  capture;
  seg_decode_t           dec;

  seg_pattern_decode u_decode (
    .pattern (s_cathode),
    .result  (dec)
  );

  // Legality and equality are judged on the incoming sample; the count
  // then says how many identical legal samples the sample register holds.
  assign raw_legal = ($countones(~anode) == 1);
  assign raw_multi = ($countones(~anode) > 1);
  assign raw_same  = (anode == s_anode) && (cathode == s_cathode);
  assign capture   = (stable_cnt == CNT_W'(STABLE_CYCLES - 1));
  assign seen_set  = seen | (NUM_DIGITS'(1) << sample_idx);

  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_anode[i]) sample_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every read in
    // this block sees the pre-edge value regardless of statement order.
    if (rst) begin
      s_anode     <= '0;
      s_cathode   <= '0;
      stable_cnt  <= '0;
      seen        <= '0;
      digits      <= {NUM_DIGITS{DIGIT_NONE}};
      digit_valid <= '0;
      digit_err   <= '0;
      update      <= 1'b0;
      update_idx  <= '0;
      frame_done  <= 1'b0;
      anode_fault <= 1'b0;
    end else begin
      s_anode    <= anode;
      s_cathode  <= cathode;
      update     <= capture;
      frame_done <= 1'b0;

      if (!raw_legal || !raw_same) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_W'(STABLE_CYCLES)) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end

      if (raw_multi) anode_fault <= 1'b1;

      // Counter saturates past the capture value, so a held pattern fires once.
      if (capture) begin
        digits[int'(sample_idx)*4 +: 4] <= dec.digit;
        digit_valid[sample_idx]         <= dec.is_digit;
        digit_err[sample_idx]           <= !dec.is_digit && !dec.is_blank;
        update_idx                      <= sample_idx;
        if (&seen_set) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_set;
        end
      end
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Monitor that watches the multiplexed 7-segment drive (active-low anodes plus shared active-low cathodes).
- Maps each qualified cathode pattern back to a BCD digit and holds one nibble per display position.
- Sits beside the display driver on the Basys3 top level.
- Used for self-check, scoreboarding in the chimp-test bench, and readback of what the player actually sees.

Parameters:
- NUM_DIGITS, 4, number of anode positions scanned.
- STABLE_CYCLES, 16, consecutive identical legal samples required before a capture; legal range 2..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- anode  input  NUM_DIGITS  active-low digit enables from the display driver.
- cathode  input  7  active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- digits  output  4*NUM_DIGITS  decoded value per position; nibble i corresponds to anode[i].
- digit_valid  output  NUM_DIGITS  position i holds a decoded 0..9.
- digit_err  output  NUM_DIGITS  last capture at position i was a non-table, non-blank pattern.
- update  output  1  one-cycle pulse on each capture.
- update_idx  output  clog2(NUM_DIGITS)  position written by the current update pulse.
- frame_done  output  1  one-cycle pulse when every position has been captured since the last frame_done or reset.
- anode_fault  output  1  sticky; set when a sample has more than one anode low.

Behaviour:
- Reset (rst high at a clock edge):
  - digits = all 4'hF; digit_valid, digit_err, update, update_idx, frame_done and anode_fault = 0.
  - Stability counter, seen-mask and sample registers cleared.
  - Reset mid-qualification discards the partial count; the next capture requires a full STABLE_CYCLES run after rst falls.
- Sampling:
  - anode and cathode are registered every cycle; they come from the same clk domain, so no synchronizer.
  - A sample is legal only when exactly one anode bit is 0.
- Stability counter:
  - Cleared when the sample is illegal, or when {anode, cathode} differs from the previous sample.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture timing:
  - Inputs held constant and legal at edges T..T+STABLE_CYCLES-1 produce update high in the cycle after edge T+STABLE_CYCLES.
  - digits, digit_valid, digit_err and update_idx change in that same cycle.
  - Exactly one capture per unbroken stable run; a held pattern never re-fires.
- Decode rules, applied to position i:
  - Table patterns (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100): nibble = value, valid=1, err=0.
  - 7'b1111111 (blank): nibble = 4'hF, valid=0, err=0.
  - Any other pattern: nibble = 4'hF, valid=0, err=1.
- Other positions are untouched by a capture.
- All-anodes-high (blanking gap):
  - Counter cleared; no capture; not a fault.
- Multiple anodes low:
  - Counter cleared; no capture; anode_fault set, cleared only by rst.
- frame_done:
  - Each capture sets seen[update_idx].
  - When seen becomes all-ones, frame_done pulses in the same cycle as that update, and seen clears in that cycle.
  - Repeated captures of a position already seen do not pulse frame_done.
- Wrap-around:
  - A scan cycle returning to position 0 restarts qualification normally.
  - A changed value overwrites the nibble.
- No backpressure: update is informational only.

Decomposition:
- Package seg_pkg holds:
  - SEG_0..SEG_9 pattern constants in bit6=a..bit0=g order.
  - SEG_BLANK = 7'b1111111.
  - DIGIT_NONE = 4'hF.
- The display driver uses the same constants.
- Sub-module seg_pattern_decode: combinational 7-bit pattern to {digit[3:0], is_digit, is_blank}, the exact inverse of the package table. It is instantiated once, on the sampled cathode.
- Sequencing (sampling, counter, capture, seen-mask) stays in the parent.

Test Plan (STABLE_CYCLES=4, NUM_DIGITS=4):
- Reset, then idle with anode=4'b1111 -> digits=16'hFFFF, digit_valid=0, no update pulse, anode_fault=0.
- anode=4'b1110, cathode=7'b0010010 held from edge T -> single update in the cycle after edge T+4, update_idx=0, digits[3:0]=2, digit_valid[0]=1; holding 20 more cycles gives no further update.
- Scan 4'b1110/4'b1101/4'b1011/4'b0111 with patterns for 1, 2, 3, 4, each held 6 cycles -> four updates, digits=16'h4321, digit_valid=4'hF, frame_done pulses with the 4th update only.
- On position 2: cathode=7'b1111111, then 7'b1010101 -> first gives nibble F with valid[2]=0, err[2]=0; second gives nibble F with err[2]=1.
- anode=4'b1100 held 10 cycles, then 4'b1110 with pattern 0011 flipped after 2 cycles -> no capture during either, anode_fault=1 stays until rst.
- rst asserted after 2 stable cycles of a valid pattern, released, same pattern re-held -> update appears only 4 sample edges after release, digits reflect the post-reset capture.
